// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the hazard scoreboard
package hazard_pkg;

  localparam int DEFAULT_NUM_REGS = 32;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - priority forward-source match for one EX operand
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              en,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_we,
  output fwd_sel_e          sel
);

  // The younger EX/MEM result shadows the older MEM/WB one.
  always_comb begin
    sel = FWD_RF;
    if (en && (src != '0)) begin
      if (exmem_we && (exmem_rd == src))      sel = FWD_EXMEM;
      else if (memwb_we && (memwb_rd == src)) sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding, stall/bubble and MUL/DIV scoreboard; HAZARD_PERF_EN adds a stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int MAX_LAT  = 16,
  parameter int CNT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_md,
  input  logic [CNT_W-1:0]  id_md_lat,
  input  logic              flush,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              ex_is_mem,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_we,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_st,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              bubble,
  output logic              md_busy,
  output logic [31:0]       perf_stall_cnt
);

  fwd_sel_e sel_a, sel_b, sel_st;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src(ex_rs1), .en(1'b1),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .memwb_rd(memwb_rd), .memwb_we(memwb_we),
    .sel(sel_a)
  );
  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src(ex_rs2), .en(!ex_is_mem),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .memwb_rd(memwb_rd), .memwb_we(memwb_we),
    .sel(sel_b)
  );
  fwd_select #(.REG_AW(REG_AW)) u_fwd_st (
    .src(ex_rs2), .en(ex_is_mem),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .memwb_rd(memwb_rd), .memwb_we(memwb_we),
    .sel(sel_st)
  );

  assign fwd_a  = sel_a;
  assign fwd_b  = sel_b;
  assign fwd_st = sel_st;

  md_state_e            state, state_nxt;
  logic [NUM_REGS-1:0]  busy;
  logic [CNT_W-1:0]     cnt [NUM_REGS];
  logic [CNT_W-1:0]     md_cnt;
  logic [CNT_W-1:0]     lat_clamped;
  logic                 id_live, rs1_cnt, rs2_cnt;
  logic                 load_use, raw, waw, structural, stall, md_issue;

  always_comb begin
    lat_clamped = id_md_lat;
    if (id_md_lat == '0)                    lat_clamped = CNT_W'(1);
    else if (id_md_lat > CNT_W'(MAX_LAT))   lat_clamped = CNT_W'(MAX_LAT);
  end

  assign id_live    = id_valid && !flush;
  assign rs1_cnt    = id_live && id_rs1_used && (id_rs1 != '0);
  assign rs2_cnt    = id_live && id_rs2_used && (id_rs2 != '0);
  assign load_use   = ex_is_load && ex_we && (ex_rd != '0) &&
                      ((rs1_cnt && (ex_rd == id_rs1)) || (rs2_cnt && (ex_rd == id_rs2)));
  assign raw        = (rs1_cnt && busy[id_rs1]) || (rs2_cnt && busy[id_rs2]);
  assign waw        = id_live && id_rd_we && (id_rd != '0) && busy[id_rd];
  assign structural = id_live && id_is_md && (state == MD_BUSY);
  assign stall      = load_use || raw || waw || structural;
  assign md_issue   = id_live && id_is_md && id_rd_we && !stall;

  // Register 0 is never marked busy, so writes to x0 only occupy the unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (md_issue && (id_rd == REG_AW'(r))) begin
          busy[r] <= 1'b1;
          cnt[r]  <= lat_clamped;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
          if (cnt[r] == CNT_W'(1)) busy[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              md_cnt <= '0;
    else if (md_issue)       md_cnt <= lat_clamped;
    else if (md_cnt != '0)   md_cnt <= md_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_issue) state_nxt = MD_BUSY;
      MD_BUSY: if (md_cnt <= CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_busy    = (state == MD_BUSY);
    pc_write   = !stall;
    ifid_write = !stall;
    bubble     = stall;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_md, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_md_lat;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, exmem_rd, memwb_rd;
  logic        ex_is_mem, ex_we, ex_is_load, exmem_we, memwb_we;
  logic [1:0]  fwd_a, fwd_b, fwd_st;
  logic        pc_write, ifid_write, bubble, md_busy;
  logic [31:0] perf_stall_cnt;

  int n_pass = 0;
  int n_total = 0;
  int st, mb;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_md(id_is_md), .id_md_lat(id_md_lat),
    .flush(flush), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_is_mem(ex_is_mem),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .memwb_rd(memwb_rd), .memwb_we(memwb_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st),
    .pc_write(pc_write), .ifid_write(ifid_write), .bubble(bubble), .md_busy(md_busy),
    .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_md = 0; id_md_lat = 0; flush = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_is_mem = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0;
    exmem_rd = 0; exmem_we = 0; memwb_rd = 0; memwb_we = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic id_reads(input logic [4:0] rs);
    id_valid = 1; id_is_md = 0; id_rd_we = 0; id_rd = 0;
    id_rs1 = rs; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 0;
  endtask

  task automatic id_md(input logic [4:0] rd, input logic [4:0] lat);
    id_valid = 1; id_is_md = 1; id_rd_we = 1; id_rd = rd; id_md_lat = lat;
    id_rs1_used = 0; id_rs2_used = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_bubble", bubble, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_perf", perf_stall_cnt, 0);
    next_cycle();
    rst_n = 1;
    next_cycle();

    // Forwarding
    ex_rs1 = 5; exmem_rd = 5; exmem_we = 1; memwb_rd = 5; memwb_we = 1; #1;
    chk("fwd_a_exmem_prio", fwd_a, 2'b01);
    ex_rs1 = 0; #1;
    chk("fwd_a_x0", fwd_a, 2'b00);
    ex_rs1 = 5; exmem_we = 0; #1;
    chk("fwd_a_memwb", fwd_a, 2'b10);
    idle_inputs();
    ex_is_mem = 1; ex_rs2 = 7; memwb_rd = 7; memwb_we = 1; exmem_rd = 3; exmem_we = 1; #1;
    chk("fwd_st_store", fwd_st, 2'b10);
    chk("fwd_b_store", fwd_b, 2'b00);
    ex_is_mem = 0; #1;
    chk("fwd_b_alu", fwd_b, 2'b10);
    chk("fwd_st_alu", fwd_st, 2'b00);
    idle_inputs();

    // Load-use: one stall cycle
    ex_is_load = 1; ex_we = 1; ex_rd = 3; id_reads(3); #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_bubble", bubble, 1);
    chk("lu_ifid_write", ifid_write, 0);
    id_rs1_used = 0; #1;
    chk("lu_unused_src", pc_write, 1);
    id_rs1_used = 1; flush = 1; #1;
    chk("lu_flush", bubble, 0);
    flush = 0;
    next_cycle();
    ex_is_load = 0; ex_we = 0; ex_rd = 0; #1;
    chk("lu_resume", pc_write, 1);
    idle_inputs();
    next_cycle();

    // MUL x9 lat 4 followed by a dependent read
    id_md(9, 4); #1;
    chk("md_issue_nostall", pc_write, 1);
    next_cycle();
    id_reads(9);
    st = 0; mb = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!pc_write) st++;
      if (md_busy) mb++;
      next_cycle();
    end
    chk("md_raw_stall_cycles", st, 4);
    chk("md_busy_cycles", mb, 4);
`ifdef HAZARD_PERF_EN
    chk("perf_cnt", perf_stall_cnt, 5);
`else
    chk("perf_cnt", perf_stall_cnt, 0);
`endif
    idle_inputs();

    // Structural stall: second MD op waits for the unit
    id_md(10, 3);
    next_cycle();
    id_md(11, 2);
    st = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (pc_write) break;
      st++;
      next_cycle();
    end
    chk("struct_stall_cycles", st, 3);
    next_cycle();
    id_reads(0); id_rs1_used = 0; id_rd = 11; id_rd_we = 1; #1;
    chk("md2_busy", md_busy, 1);
    chk("waw_stall", bubble, 1);
    id_rd = 0; #1;
    chk("waw_x0_nostall", bubble, 0);
    id_reads(11); #1;
    chk("raw_x11_stall", pc_write, 0);

    // Asynchronous reset mid-op
    #1 rst_n = 0; #1;
    chk("mid_rst_pc_write", pc_write, 1);
    chk("mid_rst_md_busy", md_busy, 0);
    chk("mid_rst_perf", perf_stall_cnt, 0);
    next_cycle();
    rst_n = 1;
    next_cycle();
    chk("post_rst_no_raw", pc_write, 1);

    // Zero latency clamps to one stall cycle
    id_md(12, 0);
    next_cycle();
    id_reads(12);
    st = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (!pc_write) st++;
      next_cycle();
    end
    chk("lat0_clamp_stall", st, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
